// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor scan sequencer: FSM encodings,
// channel indices and the ADC code width used across the sensor front end.
package sensor_pkg;

    localparam int ADC_RESOLUTION = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } scan_state_t;

    localparam logic [1:0] CH_SOIL  = 2'd0;
    localparam logic [1:0] CH_DHT11 = 2'd1;
    localparam logic [1:0] CH_RAIN  = 2'd2;

    // Enable vector {rain, dht11, soil}; out-of-range index gives all zero.
    function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
        return 3'b001 << ch;
    endfunction

endpackage

// File: rtl/sensor_scan_controller_timer.sv
// Periodic auto-trigger: one-cycle timer_tick every SCAN_PERIOD cycles while
// auto_en is high; the count restarts from zero whenever auto_en drops.
module scan_timer #(
    parameter int SCAN_PERIOD = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic auto_en,
    output logic timer_tick
);

    localparam int TW = $clog2(SCAN_PERIOD + 1);

    logic [TW-1:0] cnt;

    // cnt == 0 means "reload"; the tick is registered one cycle after cnt hits 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            timer_tick <= 1'b0;
        end else if (!auto_en) begin
            cnt        <= '0;
            timer_tick <= 1'b0;
        end else begin
            timer_tick <= (cnt == TW'(1));
            cnt        <= (cnt == '0) ? TW'(SCAN_PERIOD - 1) : cnt - TW'(1);
        end
    end

endmodule

// File: rtl/sensor_scan_controller.sv
// Sequences soil/DHT11/rain ADCs: settle, burst-average, then publish all
// three averages at once with a one-cycle result_valid strobe.
module sensor_scan_controller
    import sensor_pkg::*;
#(
    parameter int RESOLUTION    = ADC_RESOLUTION,
    parameter int SETTLE_CYCLES = 4,
    parameter int AVG_LOG2      = 2,
    parameter int SCAN_PERIOD   = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  auto_en,
    input  logic                  clr_overrun,
    input  logic [RESOLUTION-1:0] soil_digital,
    input  logic [RESOLUTION-1:0] dht11_digital,
    input  logic [RESOLUTION-1:0] rain_digital,
    output logic                  soil_en,
    output logic                  dht11_en,
    output logic                  rain_en,
    output logic [RESOLUTION-1:0] soil_avg,
    output logic [RESOLUTION-1:0] dht11_avg,
    output logic [RESOLUTION-1:0] rain_avg,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  overrun
);

    // state     | meaning
    // ST_IDLE   | waiting for start or timer_tick
    // ST_SETTLE | channel enabled, samples discarded
    // ST_SAMPLE | accumulating N samples of channel ch
    // ST_DONE   | outputs just published, result_valid high

    localparam int N     = 1 << AVG_LOG2;
    localparam int ACC_W = RESOLUTION + AVG_LOG2;
    localparam int CNT_W = 8;

    scan_state_t           state;
    logic [1:0]            ch;
    logic [CNT_W-1:0]      cnt;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      acc_sum;
    logic [RESOLUTION-1:0] sel_code;
    logic [RESOLUTION-1:0] avg_of;
    logic [RESOLUTION-1:0] hold_soil;
    logic [RESOLUTION-1:0] hold_dht11;
    logic [2:0]            en;
    logic                  timer_tick;
    logic                  trigger;

    scan_timer #(.SCAN_PERIOD(SCAN_PERIOD)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .auto_en    (auto_en),
        .timer_tick (timer_tick)
    );

    always_comb begin
        sel_code = rain_digital;
        unique case (ch)
            CH_SOIL:  sel_code = soil_digital;
            CH_DHT11: sel_code = dht11_digital;
            default:  sel_code = rain_digital;
        endcase
    end

    assign acc_sum = acc + ACC_W'(sel_code);
    assign avg_of  = acc_sum[ACC_W-1:AVG_LOG2];
    assign trigger = start | timer_tick;

    assign soil_en  = en[0];
    assign dht11_en = en[1];
    assign rain_en  = en[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            ch           <= CH_SOIL;
            cnt          <= '0;
            acc          <= '0;
            hold_soil    <= '0;
            hold_dht11   <= '0;
            soil_avg     <= '0;
            dht11_avg    <= '0;
            rain_avg     <= '0;
            en           <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            result_valid <= 1'b0;

            if (timer_tick && state != ST_IDLE)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        state <= ST_SETTLE;
                        ch    <= CH_SOIL;
                        acc   <= '0;
                        cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        en    <= ch_onehot(CH_SOIL);
                        busy  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_SAMPLE;
                        cnt   <= CNT_W'(N - 1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (cnt != '0) begin
                        acc <= acc_sum;
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        acc <= '0;
                        if (ch == CH_SOIL)
                            hold_soil <= avg_of;
                        if (ch == CH_DHT11)
                            hold_dht11 <= avg_of;
                        if (ch != CH_RAIN) begin
                            ch    <= ch + 2'd1;
                            state <= ST_SETTLE;
                            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                            en    <= ch_onehot(ch + 2'd1);
                        end else begin
                            // Rain's average bypasses its holding stage so all
                            // three outputs change on the same edge.
                            state        <= ST_DONE;
                            en           <= '0;
                            soil_avg     <= hold_soil;
                            dht11_avg    <= hold_dht11;
                            rain_avg     <= avg_of;
                            result_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_scan_controller.sv
// Directed bench for sensor_scan_controller: scan timing, averaging,
// overrun handling, start filtering and asynchronous reset.
module tb_sensor_scan_controller;

    localparam int RES = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           auto_en;
    logic           clr_overrun;
    logic [RES-1:0] soil_digital;
    logic [RES-1:0] dht11_digital;
    logic [RES-1:0] rain_digital;
    logic           soil_en;
    logic           dht11_en;
    logic           rain_en;
    logic [RES-1:0] soil_avg;
    logic [RES-1:0] dht11_avg;
    logic [RES-1:0] rain_avg;
    logic           result_valid;
    logic           busy;
    logic           overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    sensor_scan_controller #(
        .RESOLUTION    (RES),
        .SETTLE_CYCLES (4),
        .AVG_LOG2      (2),
        .SCAN_PERIOD   (20)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .auto_en       (auto_en),
        .clr_overrun   (clr_overrun),
        .soil_digital  (soil_digital),
        .dht11_digital (dht11_digital),
        .rain_digital  (rain_digital),
        .soil_en       (soil_en),
        .dht11_en      (dht11_en),
        .rain_en       (rain_en),
        .soil_avg      (soil_avg),
        .dht11_avg     (dht11_avg),
        .rain_avg      (rain_avg),
        .result_valid  (result_valid),
        .busy          (busy),
        .overrun       (overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected {rain,dht11,soil} enables for cycle k of a scan started at cycle 0.
    function automatic logic [2:0] exp_en(input int k);
        if (k >= 1 && k <= 8)   return 3'b001;
        if (k >= 9 && k <= 16)  return 3'b010;
        if (k >= 17 && k <= 24) return 3'b100;
        return 3'b000;
    endfunction

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; auto_en = 1'b0; clr_overrun = 1'b0;
        soil_digital = '0; dht11_digital = '0; rain_digital = '0;
        step(); step();
        n_cmp++;
        if ({soil_en, dht11_en, rain_en, soil_avg, dht11_avg, rain_avg, result_valid, busy, overrun} !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got en=%b%b%b avg=%0d/%0d/%0d rv=%b busy=%b ovr=%b, want all 0",
                     rain_en, dht11_en, soil_en, soil_avg, dht11_avg, rain_avg, result_valid, busy, overrun);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_scan();
        int rv_cnt = 0;
        int rv_at  = -1;
        soil_digital = 10'd512; dht11_digital = 10'd100; rain_digital = 10'd1023;
        start = 1'b1;
        cyc = 0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_c0: got %b want 0", busy);
        end
        for (int k = 1; k <= 30; k++) begin
            step();
            start = 1'b0;
            n_cmp++;
            if ({rain_en, dht11_en, soil_en} !== exp_en(cyc)) begin
                n_bad++;
                $display("FAIL basic_enables c%0d: got %b want %b", cyc, {rain_en, dht11_en, soil_en}, exp_en(cyc));
            end
            n_cmp++;
            if (busy !== (cyc <= 25)) begin
                n_bad++;
                $display("FAIL basic_busy c%0d: got %b want %b", cyc, busy, (cyc <= 25));
            end
            if (result_valid === 1'b1) begin
                rv_cnt++;
                rv_at = cyc;
                n_cmp++;
                if ({soil_avg, dht11_avg, rain_avg} !== {10'd512, 10'd100, 10'd1023}) begin
                    n_bad++;
                    $display("FAIL basic_avgs: got %0d/%0d/%0d want 512/100/1023", soil_avg, dht11_avg, rain_avg);
                end
            end
        end
        n_cmp++;
        if (rv_cnt != 1 || rv_at != 25) begin
            n_bad++;
            $display("FAIL basic_result_valid: got %0d strobes last at c%0d, want 1 at c25", rv_cnt, rv_at);
        end
    endtask

    task automatic test_truncation();
        soil_digital = 10'd103; dht11_digital = 10'd7; rain_digital = 10'd2;
        start = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            start = 1'b0;
            soil_digital = (cyc % 2 == 1) ? 10'd100 : 10'd103;
            rain_digital = (cyc % 2 == 1) ? 10'd1 : 10'd2;
        end
        n_cmp++;
        if (result_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL trunc_result_valid c25: got %b want 1", result_valid);
        end
        n_cmp++;
        if (soil_avg !== 10'd101) begin
            n_bad++;
            $display("FAIL trunc_soil_avg: got %0d want 101", soil_avg);
        end
        n_cmp++;
        if (dht11_avg !== 10'd7 || rain_avg !== 10'd1) begin
            n_bad++;
            $display("FAIL trunc_dht_rain: got %0d/%0d want 7/1", dht11_avg, rain_avg);
        end
        step();
    endtask

    task automatic test_start_ignored();
        int rv_cnt = 0;
        int rv_at  = -1;
        logic seen = 1'b0;
        soil_digital = 10'd300; dht11_digital = 10'd200; rain_digital = 10'd100;
        start = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 26; k++) begin
            step();
            start = (cyc == 10);
            if (result_valid === 1'b1) begin
                rv_cnt++;
                rv_at = cyc;
            end
        end
        n_cmp++;
        if (rv_cnt != 1 || rv_at != 25) begin
            n_bad++;
            $display("FAIL ignored_start_rv: got %0d strobes last at c%0d, want 1 at c25", rv_cnt, rv_at);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_start_busy_c26: got %b want 0", busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || soil_en !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_c26_start: got busy=%b soil_en=%b want 1/1", busy, soil_en);
        end
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (result_valid === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || {soil_avg, dht11_avg, rain_avg} !== {10'd300, 10'd200, 10'd100}) begin
            n_bad++;
            $display("FAIL accepted_scan: got seen=%b avg=%0d/%0d/%0d want 1 300/200/100", seen, soil_avg, dht11_avg, rain_avg);
        end
        step();
    endtask

    task automatic test_overrun();
        int rv_cnt = 0;
        auto_en = 1'b1;
        start = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            start = 1'b0;
            if (result_valid === 1'b1) rv_cnt++;
            if (cyc == 20) begin
                n_cmp++;
                if (overrun !== 1'b0) begin
                    n_bad++;
                    $display("FAIL overrun_c20: got %b want 0", overrun);
                end
            end
            if (cyc == 21) begin
                n_cmp++;
                if (overrun !== 1'b1) begin
                    n_bad++;
                    $display("FAIL overrun_c21: got %b want 1", overrun);
                end
            end
        end
        auto_en = 1'b0;
        step();
        n_cmp++;
        if (rv_cnt != 1 || busy !== 1'b0 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_no_extra_scan: got rv=%0d busy=%b ovr=%b want 1/0/1", rv_cnt, busy, overrun);
        end
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clear: got %b want 0", overrun);
        end
        auto_en = 1'b1;
        start = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 27; k++) begin
            step();
            start = 1'b0;
            clr_overrun = (cyc == 20);
            if (cyc == 21) begin
                n_cmp++;
                if (overrun !== 1'b1) begin
                    n_bad++;
                    $display("FAIL overrun_set_beats_clear: got %b want 1", overrun);
                end
            end
        end
        auto_en = 1'b0;
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_scan();
        int rv_cnt = 0;
        logic ever_busy = 1'b0;
        soil_digital = 10'd512; dht11_digital = 10'd100; rain_digital = 10'd1023;
        start = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            start = 1'b0;
        end
        n_cmp++;
        if (dht11_en !== 1'b1) begin
            n_bad++;
            $display("FAIL midscan_c12_dht_en: got %b want 1", dht11_en);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({soil_en, dht11_en, rain_en, soil_avg, dht11_avg, rain_avg, result_valid, busy, overrun} !== '0) begin
            n_bad++;
            $display("FAIL midscan_reset_clears: got en=%b%b%b avg=%0d/%0d/%0d rv=%b busy=%b",
                     rain_en, dht11_en, soil_en, soil_avg, dht11_avg, rain_avg, result_valid, busy);
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (result_valid === 1'b1) rv_cnt++;
            if (busy === 1'b1) ever_busy = 1'b1;
        end
        n_cmp++;
        if (rv_cnt != 0 || ever_busy) begin
            n_bad++;
            $display("FAIL midscan_no_resume: got rv=%0d busy_seen=%b want 0/0", rv_cnt, ever_busy);
        end
        start = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 25; k++) begin
            step();
            start = 1'b0;
        end
        n_cmp++;
        if (result_valid !== 1'b1 || {soil_avg, dht11_avg, rain_avg} !== {10'd512, 10'd100, 10'd1023}) begin
            n_bad++;
            $display("FAIL post_reset_scan: got rv=%b avg=%0d/%0d/%0d want 1 512/100/1023",
                     result_valid, soil_avg, dht11_avg, rain_avg);
        end
        step();
    endtask

    task automatic test_coincident();
        int rv_cnt = 0;
        int rv_at  = -1;
        auto_en = 1'b1;
        cyc = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            start = (cyc == 20);
            if (cyc == 21) auto_en = 1'b0;
            if (result_valid === 1'b1) begin
                rv_cnt++;
                rv_at = cyc;
            end
        end
        n_cmp++;
        if (rv_cnt != 1 || rv_at != 45) begin
            n_bad++;
            $display("FAIL coincident_one_scan: got %0d strobes last at c%0d, want 1 at c45", rv_cnt, rv_at);
        end
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL coincident_overrun: got %b want 0", overrun);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_scan();
        test_truncation();
        test_start_ignored();
        test_overrun();
        test_reset_mid_scan();
        test_coincident();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
